uart_rx_buffered: RTL and testbench

//  UART receive front end. Deserialises 8N1 frames from the rx pin using a 16x oversampling tick.

---
 rtl/uart_rx_buffered_pkg.sv | 11 +
 rtl/uart_fifo.sv | 43 ++++
 rtl/uart_rx_buffered.sv | 98 +++++++++
 tb/tb_uart_rx_buffered.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// uart_rx_buffered_pkg: shared UART state encodings and oversampling constants
package uart_rx_buffered_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_START = 7;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through byte FIFO with registered empty/full flags
module uart_fifo #(
  parameter int DBIT = 8,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full
);
  logic [DBIT-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr & (~full | rd);
  assign do_rd = rd & ~empty;
  assign r_data = mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wp] <= w_data;
        wp <= wp + 1'b1;
      end
      if (do_rd) rp <= rp + 1'b1;
      if (do_wr && !do_rd) begin
        empty <= 1'b0;
        full <= ADDR_W'(wp + 1'b1) == rp;
      end
      if (do_rd && !do_wr) begin
        full <= 1'b0;
        empty <= ADDR_W'(rp + 1'b1) == wp;
      end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 16x-oversampled 8N1 receiver feeding a small FWFT FIFO
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun
);
  localparam int NW = $clog2(DBIT);
  logic rx_m, rx_s;
  state_t state, state_n;
  logic [3:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic push, fe;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      frame_err <= fe;
      overrun <= push & rx_full & ~rd_uart;
    end
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    push = 1'b0;
    fe = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = START;
          s_n = '0;
        end
      START:
        if (s_tick) begin
          if (s == 4'(MID_START)) begin
            state_n = rx_s ? IDLE : DATA;
            s_n = '0;
            n_n = '0;
          end else s_n = s + 4'd1;
        end
      DATA:
        if (s_tick) begin
          if (s == 4'(OVERSAMPLE - 1)) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            state_n = (n == NW'(DBIT - 1)) ? STOP : DATA;
            n_n = (n == NW'(DBIT - 1)) ? n : n + 1'b1;
          end else s_n = s + 4'd1;
        end
      STOP:
        if (s_tick) begin
          if (s == 4'(SB_TICK - 1)) begin
            state_n = IDLE;
            push = rx_s;
            fe = ~rx_s;
          end else s_n = s + 4'd1;
        end
      default: state_n = IDLE;
    endcase
  end
  uart_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) fifo (
    .clk(clk),
    .reset(reset),
    .wr(push),
    .w_data(b),
    .rd(rd_uart),
    .r_data(r_data),
    .empty(rx_empty),
    .full(rx_full)
  );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed vector and corner-sequence bench for uart_rx_buffered
module tb_uart_rx_buffered;
  import uart_rx_buffered_pkg::*;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, s_tick = 1'b0, rd_uart = 1'b0;
  logic [7:0] r_data;
  logic rx_empty, rx_full, frame_err, overrun;
  int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0;
  typedef struct {
    logic [7:0] data;
    logic stop;
    logic exp_empty;
    int exp_fe;
  } vec_t;
  vec_t vecs[6];
  uart_rx_buffered dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rd_uart(rd_uart),
    .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (3) @(negedge clk);
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  end
  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    rx = stop;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
  endtask
  task automatic pop();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask
  initial begin
    int f0, o0, found, cyc;
    logic [7:0] d6;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 0};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1};
    repeat (5) @(negedge clk);
    chk("reset_empty", 32'(rx_empty), 1);
    chk("reset_full", 32'(rx_full), 0);
    chk("reset_rdata", 32'(r_data), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_ovr", 32'(overrun), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      f0 = fe_cnt;
      send(vecs[i].data, vecs[i].stop);
      chk($sformatf("vec%0d_empty", i), 32'(rx_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_ferr", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
      if (!vecs[i].exp_empty) begin
        chk($sformatf("vec%0d_data", i), 32'(r_data), 32'(vecs[i].data));
        pop();
      end
      chk($sformatf("vec%0d_empty_after", i), 32'(rx_empty), 1);
    end
    f0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_empty", 32'(rx_empty), 1);
    chk("glitch_ferr", 32'(fe_cnt - f0), 0);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    o0 = ov_cnt;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1);
      if (k == 3) chk("fill3_full", 32'(rx_full), 0);
      if (k == 4) chk("fill4_full", 32'(rx_full), 1);
    end
    chk("ovr_pulse", 32'(ov_cnt - o0), 1);
    chk("ovr_full", 32'(rx_full), 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovr_pop%0d", k), 32'(r_data), 32'(k));
      pop();
    end
    chk("ovr_drained", 32'(rx_empty), 1);
    chk("ovr_notfull", 32'(rx_full), 0);
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b1);
    chk("sim_full", 32'(rx_full), 1);
    o0 = ov_cnt;
    found = 0;
    fork
      send(8'h05, 1'b1);
      begin
        cyc = 0;
        while (cyc < 1200 && found == 0) begin
          @(negedge clk);
          #1;
          if (dut.push) found = 1;
          else cyc++;
        end
        if (found != 0) begin
          rd_uart = 1'b1;
          @(posedge clk);
          #1;
          rd_uart = 1'b0;
        end
      end
    join
    chk("sim_push_seen", 32'(found), 1);
    chk("sim_no_ovr", 32'(ov_cnt - o0), 0);
    chk("sim_still_full", 32'(rx_full), 1);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("sim_pop%0d", k), 32'(r_data), 32'(k));
      pop();
    end
    chk("sim_drained", 32'(rx_empty), 1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    chk("rst_buffered", 32'(rx_empty), 0);
    d6 = 8'h6B;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d6[i];
      repeat (64) @(negedge clk);
    end
    rx = d6[4];
    repeat (32) @(negedge clk);
    chk("rst_in_data", 32'(dut.state), 32'(DATA));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(rx_empty), 1);
    chk("rst_full", 32'(rx_full), 0);
    chk("rst_rdata", 32'(r_data), 0);
    chk("rst_idle", 32'(dut.state), 32'(IDLE));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_still_empty", 32'(rx_empty), 1);
    send(8'h7E, 1'b1);
    chk("post_rst_empty", 32'(rx_empty), 0);
    chk("post_rst_data", 32'(r_data), 32'h7E);
    pop();
    chk("post_rst_drained", 32'(rx_empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
